// File: rtl/ripple_mon_pkg.sv
// Shared types for the ripple counter monitor: filter states, buffered entry
// layout and buffer depth.
package ripple_mon_pkg;

  localparam int unsigned ENTRY_EXT_W = 8;
  localparam int unsigned FIFO_DEPTH  = 2;

  typedef enum logic {
    TRACK  = 1'b0,
    SETTLE = 1'b1
  } state_t;

  typedef struct packed {
    logic [ENTRY_EXT_W-1:0] count;
    logic                   wrap;
  } entry_t;

endpackage

// File: rtl/ripple_mon_fifo.sv
// Two-entry first-word-fall-through buffer of accepted counts.
// Head is always mem[0]; a pop shifts the second entry forward.
module ripple_mon_fifo
  import ripple_mon_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic   drop
);

  entry_t     mem [0:FIFO_DEPTH-1];
  logic [1:0] cnt;
  logic       pop_ok;
  logic       push_ok;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'(FIFO_DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign head    = mem[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (pop_ok) begin
      mem[0] <= mem[1];
      // After the shift the free slot is one below the current fill level.
      if (push_ok) begin
        if (cnt == 2'd2) mem[1] <= push_data;
        else             mem[0] <= push_data;
      end
      if (!push_ok) cnt <= cnt - 2'd1;
    end else if (push_ok) begin
      if (cnt[0]) mem[1] <= push_data;
      else        mem[0] <= push_data;
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// Synchronises and de-glitches an asynchronous ripple counter, extends it to a
// wide count and buffers each accepted value for a valid/ready consumer.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned EXT_W         = ENTRY_EXT_W,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             err_clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [EXT_W-1:0] out_count,
  output logic             out_wrap,
  output logic             step_err,
  output logic             overrun
);

  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] sync1, sync2;
  logic [CNT_W-1:0] last, cand;
  logic [EXT_W-1:0] ext;
  logic [3:0]       stab;
  state_t           state;

  logic [CNT_W-1:0] delta;
  logic [EXT_W-1:0] ext_next;
  logic             wrap;
  logic             accept;

  entry_t push_entry;
  entry_t head;
  logic   fifo_full, fifo_empty, fifo_drop;

  assign delta    = cand - last;
  assign ext_next = ext + {{(EXT_W-CNT_W){1'b0}}, delta};
  assign wrap     = (cand < last);
  assign accept   = (state == SETTLE) && (sync2 == cand) && (stab == STAB_LAST);

  always_comb begin
    push_entry       = '0;
    push_entry.count = ext_next;
    push_entry.wrap  = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      last  <= '0;
      cand  <= '0;
      ext   <= '0;
      stab  <= '0;
      state <= TRACK;
    end else begin
      sync1 <= cnt_in;
      sync2 <= sync1;
      case (state)
        TRACK: begin
          if (sync2 != last) begin
            cand  <= sync2;
            stab  <= 4'd1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 == cand) begin
            if (stab == STAB_LAST) begin
              ext   <= ext_next;
              last  <= cand;
              state <= TRACK;
            end else begin
              stab <= stab + 4'd1;
            end
          end else if (sync2 == last) begin
            state <= TRACK;
          end else begin
            cand <= sync2;
            stab <= 4'd1;
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

  // Set takes priority over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accept && (delta != CNT_W'(1))) step_err <= 1'b1;
      else if (err_clr)                   step_err <= 1'b0;
      if (fifo_drop && fifo_full)         overrun  <= 1'b1;
      else if (err_clr)                   overrun  <= 1'b0;
    end
  end

  ripple_mon_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign out_valid = !fifo_empty;
  assign out_count = head.count;
  assign out_wrap  = head.wrap;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with default parameters.
module tb_ripple_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cnt_in;
  logic       err_clr;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_count;
  logic       out_wrap;
  logic       step_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] cnt;
    logic [7:0] count;
    logic       wrap;
    logic       step;
  } vec_t;

  vec_t vecs [0:8];

  ripple_count_monitor #(.CNT_W(3), .EXT_W(8), .STABLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .err_clr   (err_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_wrap  (out_wrap),
    .step_err  (step_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] val);
    rst    = 1'b1;
    cnt_in = val;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive a value, then expect the push exactly at the fourth edge.
  task automatic step(input logic [2:0] val, input logic [7:0] exp_count,
                      input logic exp_wrap, input logic exp_step, input string name);
    cnt_in = val;
    tick();
    tick();
    tick();
    check({name, "_early_valid"}, out_valid, 0);
    tick();
    check({name, "_valid"}, out_valid, 1);
    check({name, "_count"}, out_count, exp_count);
    check({name, "_wrap"}, out_wrap, exp_wrap);
    check({name, "_step_err"}, step_err, exp_step);
  endtask

  task automatic apply(input logic [2:0] val);
    cnt_in = val;
    repeat (4) tick();
  endtask

  initial begin
    int pushes;
    logic [7:0] seen;

    vecs[0] = '{3'd1, 8'd1, 1'b0, 1'b0};
    vecs[1] = '{3'd2, 8'd2, 1'b0, 1'b0};
    vecs[2] = '{3'd3, 8'd3, 1'b0, 1'b0};
    vecs[3] = '{3'd4, 8'd4, 1'b0, 1'b0};
    vecs[4] = '{3'd5, 8'd5, 1'b0, 1'b0};
    vecs[5] = '{3'd6, 8'd6, 1'b0, 1'b0};
    vecs[6] = '{3'd7, 8'd7, 1'b0, 1'b0};
    vecs[7] = '{3'd0, 8'd8, 1'b1, 1'b0};
    vecs[8] = '{3'd2, 8'd10, 1'b0, 1'b1};

    err_clr   = 1'b0;
    out_ready = 1'b1;

    do_reset(3'd5);
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_step_err", step_err, 0);
    check("rst_overrun", overrun, 0);
    step(3'd5, 8'd5, 1'b0, 1'b1, "after_rst5");

    do_reset(3'd0);
    for (int i = 0; i < 9; i++) step(vecs[i].cnt, vecs[i].count, vecs[i].wrap, vecs[i].step, $sformatf("vec%0d", i));

    // Glitch towards 3 that falls back to last=2 must not push.
    do_reset(3'd0);
    step(3'd1, 8'd1, 1'b0, 1'b0, "g_pre1");
    step(3'd2, 8'd2, 1'b0, 1'b0, "g_pre2");
    cnt_in = 3'd3;
    tick();
    cnt_in = 3'd2;
    pushes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) pushes++;
    end
    check("glitch_pushes", pushes, 0);

    // Skip 2 -> 5, with err_clr held across the accept: set wins.
    err_clr = 1'b1;
    step(3'd5, 8'd5, 1'b0, 1'b1, "skip");
    tick();
    err_clr = 1'b0;
    check("err_clr_step_err", step_err, 0);

    // Transient 0 then 6 from last=5: one push, delta 1.
    cnt_in = 3'd0;
    tick();
    cnt_in = 3'd6;
    pushes = 0;
    seen   = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) begin
        pushes++;
        seen = out_count;
      end
    end
    check("transient_pushes", pushes, 1);
    check("transient_count", seen, 6);
    check("transient_step_err", step_err, 0);

    // Backpressure: third entry is dropped.
    do_reset(3'd0);
    out_ready = 1'b0;
    apply(3'd1);
    check("bp1_valid", out_valid, 1);
    check("bp1_count", out_count, 1);
    apply(3'd2);
    check("bp2_count", out_count, 1);
    check("bp2_overrun", overrun, 0);
    apply(3'd3);
    check("bp3_count", out_count, 1);
    check("bp3_overrun", overrun, 1);
    out_ready = 1'b1;
    check("drain_head1", out_count, 1);
    tick();
    check("drain_valid2", out_valid, 1);
    check("drain_head2", out_count, 2);
    check("drain_wrap2", out_wrap, 0);
    tick();
    check("drain_empty", out_valid, 0);

    // Reset one clock into SETTLE, with an entry buffered.
    do_reset(3'd0);
    out_ready = 1'b0;
    apply(3'd1);
    check("flush_pre_valid", out_valid, 1);
    cnt_in = 3'd2;
    tick();
    tick();
    tick();
    rst    = 1'b1;
    cnt_in = 3'd0;
    tick();
    rst = 1'b0;
    check("midsettle_valid", out_valid, 0);
    check("midsettle_step_err", step_err, 0);
    out_ready = 1'b1;
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) pushes++;
    end
    check("midsettle_pushes", pushes, 0);
    step(3'd1, 8'd1, 1'b0, 1'b0, "post_midsettle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_count_monitor.md
# ripple_count_monitor

Downstream consumer of the asynchronous 3-bit ripple up-counter. It synchronises the counter's `q` bus into the system clock domain and filters ripple transients so only settled values are accepted. It extends the count to a wide binary value, flags wrap and skipped-step errors, and hands each accepted count to the next stage over a valid/ready interface with a 2-entry buffer.

## Interface
- `CNT_W`, default 3: width of the incoming ripple count.
- `EXT_W`, default 8: width of the extended output count; must be greater than `CNT_W`.
- `STABLE_CYCLES`, default 2: consecutive identical synchronised samples required before a value is accepted. Legal range is 2..15.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `cnt_in`  in  CNT_W: raw ripple counter output. Asynchronous to `clk` and may be mid-ripple when sampled.
- `err_clr`  in  1: clears `step_err` and `overrun`.
- `out_ready`  in  1: downstream ready.
- `out_valid`  out  1: buffered entry available.
- `out_count`  out  EXT_W: extended count of the head entry.
- `out_wrap`  out  1: head entry crossed the `CNT_W` boundary.
- `step_err`  out  1: sticky; an accepted value was not last+1 (mod 2^CNT_W).
- `overrun`  out  1: sticky; an accepted value was dropped because the buffer was full.

## Operation
- Synchroniser: `sync1 <= cnt_in`, then `sync2 <= sync1`. The filter sees only `sync2`.
- Registers:
  - `last`: last accepted raw value.
  - `ext`: extended count, EXT_W bits.
  - `cand`: candidate value.
  - `stab`: 4-bit match counter.
- FSM states are TRACK and SETTLE.
- In TRACK:
  - If `sync2 != last`: `cand <= sync2`, `stab <= 1`, go to SETTLE.
  - Otherwise stay in TRACK.
- In SETTLE:
  - If `sync2 == cand` and `stab == STABLE_CYCLES-1`: ACCEPT, then go to TRACK.
  - Else if `sync2 == cand`: `stab++`.
  - Else if `sync2 == last`: go to TRACK with no accept (glitch rejected).
  - Else: `cand <= sync2`, `stab <= 1` (restart on the new candidate).
- ACCEPT, all in the same edge:
  - `delta = (cand - last) mod 2^CNT_W`.
  - `ext <= ext + delta` (mod 2^EXT_W).
  - `wrap = (cand < last)`.
  - `last <= cand`.
  - If `delta != 1`, set `step_err`.
  - Push `{ext+delta, wrap}` into the buffer.
- Buffer: 2-entry first-word-fall-through FIFO.
  - A pop occurs when `out_valid && out_ready`.
  - Push while full with no pop in the same cycle: the entry is dropped and `overrun` is set.
  - Push while full with a pop in the same cycle: the entry is accepted.
  - Order is preserved.
- `out_count` and `out_wrap` must hold steady while `out_valid && !out_ready`.
- Sticky flags: if `err_clr` and a set event occur in the same cycle, set wins.
- Upstream constraint: `cnt_in` may change at most once per `STABLE_CYCLES+2` clocks. Faster inputs are filtered out, which is defined behaviour, not an error.
- An upstream counter reset shows up as a jump to 0. It is accepted as a normal value with `wrap=1`, and `step_err` is set unless the jump is from 2^CNT_W-1.

## Timing
- Reset values:
  - `sync1`, `sync2`, `last`, `ext`, `cand`, `stab` = 0.
  - State = TRACK.
  - FIFO empty: `out_valid=0`, `out_count=0`, `out_wrap=0`.
  - `step_err=0`, `overrun=0`.
- Reset mid-SETTLE: the candidate is discarded, nothing is pushed, and the buffered entries are flushed.
- Latency: if `cnt_in` is first captured by `sync1` at edge E0, ACCEPT and the push happen at edge E0+STABLE_CYCLES+1. `out_valid` is high in the cycle after that edge.
  - With the default, E0 → push at E3, and `out_valid` is visible after E3.
- Throughput: one accept per `STABLE_CYCLES+2` clocks maximum. The buffer absorbs 2 entries of backpressure.
- `step_err` and `overrun` rise in the cycle after the causing edge.

## Structure
- `ripple_mon_pkg` holds:
  - `state_t` enum {TRACK, SETTLE}.
  - `entry_t` struct {count[EXT_W-1:0], wrap}, parameterised via a package localparam, with default `EXT_W`.
  - `FIFO_DEPTH = 2`.
- Sub-module `ripple_mon_fifo`: 2-deep FWFT FIFO of `entry_t`, with push, pop, full, empty, and a `drop` output.
- The top level holds the synchroniser, the filter FSM, the extension arithmetic, and the sticky flags.

## Test plan
- Reset: hold `rst` for 2 clocks with `cnt_in=5` → `out_valid=0`, `step_err=0`, `overrun=0`. After release, 5 is accepted as `out_count=5` and `step_err=1`.
- Clean count: from reset, step `cnt_in` 1,2,…,7,0 every 4 clocks with `out_ready=1` → `out_count` = 1..8 in order, `out_wrap=1` only at 8, `step_err=0`. Each `out_valid` pulse appears 3 edges after `sync1` captures the value.
- Glitches:
  - With `last=2`, drive `cnt_in=3` for 1 clock, then back to 2 → no push.
  - Drive a transient 1→0 (1 clock) then 2 held → exactly one push, with `delta` computed from `last`.
- Skip: with `last=2`, `ext=2`, drive `cnt_in=5` → `out_count=5`, `step_err=1`. Pulse `err_clr` → `step_err=0`.
- Backpressure: with `out_ready=0`, make 3 accepted increments (1,2,3) → entries 1,2 held with `out_count=1` stable, 3 dropped, `overrun=1`. Raise `out_ready` → 1 then 2 drain, then `out_valid=0`.
- Reset mid-SETTLE: assert `rst` one clock after SETTLE is entered → no push, `ext=0`, state TRACK, `out_valid=0`.
